// File: rtl/exu_sched_if.sv
// Issue and writeback handshakes of the execute-unit scheduler.
// The upstream pipeline is the master and the scheduler is the slave.
interface exu_sched_if #(
  parameter int ALUOP_WIDTH = 5
);
  logic                   issue_valid;
  logic                   issue_ready;
  logic [ALUOP_WIDTH-1:0] issue_op;
  logic                   issue_word;
  logic [63:0]            issue_a;
  logic [63:0]            issue_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [63:0]            res_data;
  logic                   res_timeout;

  modport master (
    output issue_valid, issue_op, issue_word, issue_a, issue_b, res_ready,
    input  issue_ready, res_valid, res_data, res_timeout
  );

  modport slave (
    input  issue_valid, issue_op, issue_word, issue_a, issue_b, res_ready,
    output issue_ready, res_valid, res_data, res_timeout
  );
endinterface

// File: rtl/exu_sched.sv
// Execute-unit issue sequencer: routes one op to ALU, multiplier or divider,
// waits for completion (with watchdog), and holds the result for writeback.
module exu_sched #(
  parameter int ALUOP_WIDTH = 5,
  parameter int MUL_OP      = 15,
  parameter int DIV_OP_LO   = 16,
  parameter int MAX_WAIT    = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  exu_sched_if.slave             bus,
  input  logic                   flush,
  output logic [63:0]            unit_a,
  output logic [63:0]            unit_b,
  output logic [ALUOP_WIDTH-1:0] unit_op,
  output logic                   unit_word,
  input  logic [63:0]            alu_result,
  output logic                   mul_en,
  input  logic                   mul_ok,
  input  logic [63:0]            mul_result,
  output logic                   div_en,
  output logic                   div_signed,
  input  logic                   div_ok,
  input  logic [63:0]            div_quot,
  input  logic [63:0]            div_rem,
  output logic                   unit_kill,
  output logic                   busy
);
  localparam logic [ALUOP_WIDTH-1:0] OP_MUL  = ALUOP_WIDTH'(MUL_OP);
  localparam logic [ALUOP_WIDTH-1:0] OP_DIVS = ALUOP_WIDTH'(DIV_OP_LO);
  localparam logic [ALUOP_WIDTH-1:0] OP_REMS = ALUOP_WIDTH'(DIV_OP_LO + 2);
  localparam logic [ALUOP_WIDTH-1:0] OP_REMU = ALUOP_WIDTH'(DIV_OP_LO + 3);
  localparam logic [7:0]             WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC_ALU = 3'd1,
    S_WAIT_MUL = 3'd2,
    S_WAIT_DIV = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_r, state_n;
  logic [63:0]            unit_a_r, unit_b_r, res_data_r, res_data_n;
  logic [ALUOP_WIDTH-1:0] unit_op_r;
  logic                   unit_word_r, div_signed_r;
  logic                   mul_en_r, div_en_r, unit_kill_r, kill_n;
  logic                   res_valid_r, res_timeout_r, timeout_n;
  logic [7:0]             cnt_r, cnt_n;
  logic                   issue_ready_s, accept_s, load_s;
  logic                   issue_is_div_s, issue_is_rem_s, div_zero_s, unit_is_rem_s;
  logic [63:0]            zero_res_s;

  assign issue_ready_s  = (state_r == S_IDLE) && !flush;
  assign accept_s       = bus.issue_valid && issue_ready_s;
  assign issue_is_div_s = (bus.issue_op >= OP_DIVS) && (bus.issue_op <= OP_REMU);
  assign issue_is_rem_s = (bus.issue_op == OP_REMS) || (bus.issue_op == OP_REMU);
  assign unit_is_rem_s  = (unit_op_r == OP_REMS) || (unit_op_r == OP_REMU);
  assign div_zero_s     = bus.issue_word ? (bus.issue_b[31:0] == 32'd0) : (bus.issue_b == 64'd0);
  // x/0 yields all ones; x%0 yields the dividend (sign-extended low word for word ops)
  assign zero_res_s     = !issue_is_rem_s ? {64{1'b1}} :
                          (bus.issue_word ? {{32{bus.issue_a[31]}}, bus.issue_a[31:0]} : bus.issue_a);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, result selection, watchdog and kill decisions
  always_comb begin
    state_n    = state_r;
    res_data_n = res_data_r;
    timeout_n  = res_timeout_r;
    kill_n     = 1'b0;
    cnt_n      = 8'd0;
    load_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          load_s    = 1'b1;
          timeout_n = 1'b0;
          if (bus.issue_op == OP_MUL) begin
            state_n = S_WAIT_MUL;
          end else if (issue_is_div_s && div_zero_s) begin
            state_n    = S_DONE;
            res_data_n = zero_res_s;
          end else if (issue_is_div_s) begin
            state_n = S_WAIT_DIV;
          end else begin
            state_n = S_EXEC_ALU;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_EXEC_ALU: begin
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          res_data_n = alu_result;
          state_n    = S_DONE;
        end
      end
      S_WAIT_MUL, S_WAIT_DIV: begin
        if (flush) begin
          state_n = S_IDLE;
          kill_n  = 1'b1;
        end else if ((state_r == S_WAIT_MUL) ? mul_ok : div_ok) begin
          state_n    = S_DONE;
          res_data_n = (state_r == S_WAIT_MUL) ? mul_result :
                       (unit_is_rem_s ? div_rem : div_quot);
        end else if (cnt_r == WAIT_LIMIT) begin
          state_n    = S_DONE;
          res_data_n = 64'd0;
          timeout_n  = 1'b1;
          kill_n     = 1'b1;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      S_DONE: begin
        if (flush || bus.res_ready) begin
          state_n   = S_IDLE;
          timeout_n = 1'b0;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_a_r      <= 64'd0;
      unit_b_r      <= 64'd0;
      unit_op_r     <= '0;
      unit_word_r   <= 1'b0;
      div_signed_r  <= 1'b0;
      res_data_r    <= 64'd0;
      res_timeout_r <= 1'b0;
      res_valid_r   <= 1'b0;
      mul_en_r      <= 1'b0;
      div_en_r      <= 1'b0;
      unit_kill_r   <= 1'b0;
      cnt_r         <= 8'd0;
    end else begin
      if (load_s) begin
        unit_a_r     <= bus.issue_a;
        unit_b_r     <= bus.issue_b;
        unit_op_r    <= bus.issue_op;
        unit_word_r  <= bus.issue_word;
        div_signed_r <= (bus.issue_op == OP_DIVS) || (bus.issue_op == OP_REMS);
      end
      res_data_r    <= res_data_n;
      res_timeout_r <= timeout_n;
      res_valid_r   <= (state_n == S_DONE);
      mul_en_r      <= (state_n == S_WAIT_MUL);
      div_en_r      <= (state_n == S_WAIT_DIV);
      unit_kill_r   <= kill_n;
      cnt_r         <= cnt_n;
    end
  end

  assign bus.issue_ready = issue_ready_s;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_timeout = res_timeout_r;
  assign unit_a          = unit_a_r;
  assign unit_b          = unit_b_r;
  assign unit_op         = unit_op_r;
  assign unit_word       = unit_word_r;
  assign div_signed      = div_signed_r;
  assign mul_en          = mul_en_r;
  assign div_en          = div_en_r;
  assign unit_kill       = unit_kill_r;
  assign busy            = (state_r != S_IDLE);
endmodule
